// File: rtl/voxel_pkg.sv
// Shared defaults, reason codes and state encoding for the voxel ray stepper.
package voxel_pkg;

    localparam int DEF_COORD_W   = 6;
    localparam int DEF_MAX_VAL   = 31;
    localparam int DEF_T_W       = 16;
    localparam int DEF_MAX_STEPS = 96;

    typedef enum logic [1:0] {
        REASON_NONE  = 2'b00,
        REASON_OOB   = 2'b01,
        REASON_STEPS = 2'b10
    } reason_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        AXIS_X = 2'd0,
        AXIS_Y = 2'd1,
        AXIS_Z = 2'd2
    } axis_e;

endpackage

// File: rtl/bounds_check.sv
// Flags a voxel coordinate triple that lies outside the 0..MAX_VAL grid on any axis.
module bounds_check
    import voxel_pkg::*;
#(
    parameter int COORD_W = DEF_COORD_W,
    parameter int MAX_VAL = DEF_MAX_VAL
) (
    input  logic [COORD_W-1:0] i_ix,
    input  logic [COORD_W-1:0] i_iy,
    input  logic [COORD_W-1:0] i_iz,
    output logic               o_oob
);

    localparam logic [COORD_W-1:0] LIMIT = COORD_W'(MAX_VAL);

    assign o_oob = (i_ix > LIMIT) || (i_iy > LIMIT) || (i_iz > LIMIT);

endmodule

// File: rtl/voxel_stepper.sv
// Amanatides-Woo style voxel walker: accepts a ray setup, then emits one voxel per
// accepted beat until the ray leaves the grid, hits the step limit, or is aborted.
module voxel_stepper
    import voxel_pkg::*;
#(
    parameter int COORD_W   = DEF_COORD_W,
    parameter int MAX_VAL   = DEF_MAX_VAL,
    parameter int T_W       = DEF_T_W,
    parameter int MAX_STEPS = DEF_MAX_STEPS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic [COORD_W-1:0] start_ix,
    input  logic [COORD_W-1:0] start_iy,
    input  logic [COORD_W-1:0] start_iz,
    input  logic               step_x,
    input  logic               step_y,
    input  logic               step_z,
    input  logic [T_W-1:0]     tmax_x,
    input  logic [T_W-1:0]     tmax_y,
    input  logic [T_W-1:0]     tmax_z,
    input  logic [T_W-1:0]     tdelta_x,
    input  logic [T_W-1:0]     tdelta_y,
    input  logic [T_W-1:0]     tdelta_z,
    input  logic               abort,
    output logic               vox_valid,
    input  logic               vox_ready,
    output logic [COORD_W-1:0] vox_ix,
    output logic [COORD_W-1:0] vox_iy,
    output logic [COORD_W-1:0] vox_iz,
    output logic               vox_last,
    output logic [1:0]         vox_reason
);

    localparam int                 CNT_W    = $clog2(MAX_STEPS + 1);
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(MAX_STEPS - 1);
    localparam logic [COORD_W-1:0] LIMIT    = COORD_W'(MAX_VAL);

    state_e             r_state;
    logic [COORD_W-1:0] r_ix, r_iy, r_iz;
    logic               r_step_x, r_step_y, r_step_z;
    logic [T_W-1:0]     r_tmax_x, r_tmax_y, r_tmax_z;
    logic [T_W-1:0]     r_tdelta_x, r_tdelta_y, r_tdelta_z;
    logic [CNT_W-1:0]   r_step_cnt;

    axis_e              w_sel;
    logic [COORD_W-1:0] w_nx, w_ny, w_nz;
    logic [T_W-1:0]     w_ntx, w_nty, w_ntz;
    logic               w_cur_oob, w_nxt_oob, w_at_limit, w_last;
    reason_e            w_reason;

    function automatic logic [T_W-1:0] sat_add(input logic [T_W-1:0] a, input logic [T_W-1:0] b);
        logic [T_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[T_W] ? '1 : sum[T_W-1:0];
    endfunction

    // Smallest tMax wins; ties go to x, then y.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_sel = AXIS_Z;
        if (r_tmax_x <= r_tmax_y && r_tmax_x <= r_tmax_z) w_sel = AXIS_X;
        else if (r_tmax_y <= r_tmax_z)                    w_sel = AXIS_Y;
    end

    always_comb begin
        w_nx  = r_ix;
        w_ny  = r_iy;
        w_nz  = r_iz;
        w_ntx = r_tmax_x;
        w_nty = r_tmax_y;
        w_ntz = r_tmax_z;
        case (w_sel)
            AXIS_X: begin
                w_nx  = r_step_x ? r_ix + 1'b1 : r_ix - 1'b1;
                w_ntx = sat_add(r_tmax_x, r_tdelta_x);
            end
            AXIS_Y: begin
                w_ny  = r_step_y ? r_iy + 1'b1 : r_iy - 1'b1;
                w_nty = sat_add(r_tmax_y, r_tdelta_y);
            end
            default: begin
                w_nz  = r_step_z ? r_iz + 1'b1 : r_iz - 1'b1;
                w_ntz = sat_add(r_tmax_z, r_tdelta_z);
            end
        endcase
    end

    bounds_check #(
        .COORD_W(COORD_W),
        .MAX_VAL(MAX_VAL)
    ) u_next_bounds (
        .i_ix (w_nx),
        .i_iy (w_ny),
        .i_iz (w_nz),
        .o_oob(w_nxt_oob)
    );

    assign w_cur_oob  = (r_ix > LIMIT) || (r_iy > LIMIT) || (r_iz > LIMIT);
    assign w_at_limit = (r_step_cnt == LAST_CNT);
    assign w_last     = w_cur_oob || w_nxt_oob || w_at_limit;
    assign w_reason   = (w_cur_oob || w_nxt_oob) ? REASON_OOB :
                        w_at_limit               ? REASON_STEPS : REASON_NONE;

    assign start_ready = (r_state == ST_IDLE);
    assign vox_valid   = (r_state == ST_EMIT);
    assign vox_ix      = r_ix;
    assign vox_iy      = r_iy;
    assign vox_iz      = r_iz;
    assign vox_last    = vox_valid && w_last;
    assign vox_reason  = vox_valid ? w_reason : REASON_NONE;

    // NOTE: state is written with non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ix       <= '0;
            r_iy       <= '0;
            r_iz       <= '0;
            r_step_x   <= 1'b0;
            r_step_y   <= 1'b0;
            r_step_z   <= 1'b0;
            r_tmax_x   <= '0;
            r_tmax_y   <= '0;
            r_tmax_z   <= '0;
            r_tdelta_x <= '0;
            r_tdelta_y <= '0;
            r_tdelta_z <= '0;
            r_step_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_valid) begin
                        r_ix       <= start_ix;
                        r_iy       <= start_iy;
                        r_iz       <= start_iz;
                        r_step_x   <= step_x;
                        r_step_y   <= step_y;
                        r_step_z   <= step_z;
                        r_tmax_x   <= tmax_x;
                        r_tmax_y   <= tmax_y;
                        r_tmax_z   <= tmax_z;
                        r_tdelta_x <= tdelta_x;
                        r_tdelta_y <= tdelta_y;
                        r_tdelta_z <= tdelta_z;
                        r_step_cnt <= '0;
                        r_state    <= ST_EMIT;
                    end
                end
                default: begin
                    // Abort wins over any beat in flight; the beat itself still counts as taken.
                    if (abort) begin
                        r_state <= ST_IDLE;
                    end else if (vox_ready) begin
                        if (w_last) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_ix       <= w_nx;
                            r_iy       <= w_ny;
                            r_iz       <= w_nz;
                            r_tmax_x   <= w_ntx;
                            r_tmax_y   <= w_nty;
                            r_tmax_z   <= w_ntz;
                            r_step_cnt <= r_step_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_voxel_stepper.sv
// Self-checking bench: two stepper instances (default and MAX_STEPS=4) against a ray-walk model.
module tb_voxel_stepper;

    localparam int CW   = 6;
    localparam int TW   = 16;
    localparam int MAXV = 31;
    localparam int TSAT = 65535;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          start_valid [2];
    logic          sr          [2];
    logic          vv          [2];
    logic          vox_ready   [2];
    logic          vl          [2];
    logic [CW-1:0] o_ix        [2];
    logic [CW-1:0] o_iy        [2];
    logic [CW-1:0] o_iz        [2];
    logic [1:0]    o_reason    [2];

    logic [CW-1:0] s_ix, s_iy, s_iz;
    logic          s_sx, s_sy, s_sz;
    logic [TW-1:0] t_mx, t_my, t_mz, t_dx, t_dy, t_dz;
    logic          abort;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int x;
        int y;
        int z;
        int last;
        int reason;
    } beat_t;

    beat_t exp_q[$];

    voxel_stepper u_dut (
        .clk(clk), .rst(rst),
        .start_valid(start_valid[0]), .start_ready(sr[0]),
        .start_ix(s_ix), .start_iy(s_iy), .start_iz(s_iz),
        .step_x(s_sx), .step_y(s_sy), .step_z(s_sz),
        .tmax_x(t_mx), .tmax_y(t_my), .tmax_z(t_mz),
        .tdelta_x(t_dx), .tdelta_y(t_dy), .tdelta_z(t_dz),
        .abort(abort),
        .vox_valid(vv[0]), .vox_ready(vox_ready[0]),
        .vox_ix(o_ix[0]), .vox_iy(o_iy[0]), .vox_iz(o_iz[0]),
        .vox_last(vl[0]), .vox_reason(o_reason[0])
    );

    voxel_stepper #(.MAX_STEPS(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .start_valid(start_valid[1]), .start_ready(sr[1]),
        .start_ix(s_ix), .start_iy(s_iy), .start_iz(s_iz),
        .step_x(s_sx), .step_y(s_sy), .step_z(s_sz),
        .tmax_x(t_mx), .tmax_y(t_my), .tmax_z(t_mz),
        .tdelta_x(t_dx), .tdelta_y(t_dy), .tdelta_z(t_dz),
        .abort(abort),
        .vox_valid(vv[1]), .vox_ready(vox_ready[1]),
        .vox_ix(o_ix[1]), .vox_iy(o_iy[1]), .vox_iz(o_iz[1]),
        .vox_last(vl[1]), .vox_reason(o_reason[1])
    );

    task automatic set_ray(input int ix, input int iy, input int iz,
                           input bit sx, input bit sy, input bit sz,
                           input int mx, input int my, input int mz,
                           input int dx, input int dy, input int dz);
        s_ix = CW'(ix); s_iy = CW'(iy); s_iz = CW'(iz);
        s_sx = sx; s_sy = sy; s_sz = sz;
        t_mx = TW'(mx); t_my = TW'(my); t_mz = TW'(mz);
        t_dx = TW'(dx); t_dy = TW'(dy); t_dz = TW'(dz);
    endtask

    task automatic scramble_inputs();
        s_ix = CW'($urandom); s_iy = CW'($urandom); s_iz = CW'($urandom);
        s_sx = 1'($urandom); s_sy = 1'($urandom); s_sz = 1'($urandom);
        t_mx = TW'($urandom); t_my = TW'($urandom); t_mz = TW'($urandom);
        t_dx = TW'($urandom); t_dy = TW'($urandom); t_dz = TW'($urandom);
    endtask

    // Walk the ray with plain integer arithmetic and list every beat the consumer should see.
    task automatic build_model(input int max_steps);
        int    c  [3];
        int    n  [3];
        int    s  [3];
        int    tm [3];
        int    td [3];
        int    cnt;
        int    a;
        bit    cur_oob, nxt_oob;
        beat_t b;
        exp_q.delete();
        c[0] = int'(s_ix); c[1] = int'(s_iy); c[2] = int'(s_iz);
        s[0] = s_sx ? 1 : -1; s[1] = s_sy ? 1 : -1; s[2] = s_sz ? 1 : -1;
        tm[0] = int'(t_mx); tm[1] = int'(t_my); tm[2] = int'(t_mz);
        td[0] = int'(t_dx); td[1] = int'(t_dy); td[2] = int'(t_dz);
        cnt = 0;
        forever begin
            cur_oob = (c[0] > MAXV) || (c[1] > MAXV) || (c[2] > MAXV);
            if (tm[0] <= tm[1] && tm[0] <= tm[2]) a = 0;
            else if (tm[1] <= tm[2])              a = 1;
            else                                  a = 2;
            n = c;
            n[a] = (c[a] + s[a] + 64) % 64;
            nxt_oob = (n[0] > MAXV) || (n[1] > MAXV) || (n[2] > MAXV);
            b.x = c[0]; b.y = c[1]; b.z = c[2];
            b.last   = (cur_oob || nxt_oob || cnt == max_steps - 1) ? 1 : 0;
            b.reason = (cur_oob || nxt_oob) ? 1 : (b.last != 0) ? 2 : 0;
            exp_q.push_back(b);
            if (b.last != 0) break;
            c = n;
            tm[a] = (tm[a] + td[a] > TSAT) ? TSAT : tm[a] + td[a];
            cnt++;
        end
    endtask

    // Offer the current setup to instance sel and consume its beats.
    task automatic run_ray(input int sel, input bit rnd, input int abort_at,
                           input int rst_at, input string name);
        int idx = 0;
        int cyc = 0;
        int want_cnt;
        bit done = 1'b0;
        bit hs;
        bit stray = 1'b0;
        beat_t e;
        build_model(sel == 1 ? 4 : 96);
        @(negedge clk);
        checks++;
        if (sr[sel] !== 1'b1) begin
            failures++;
            $display("FAIL %s start_ready got %b want 1", name, sr[sel]);
        end
        start_valid[sel] = 1'b1;
        @(negedge clk);
        if (rnd) scramble_inputs();
        else     start_valid[sel] = 1'b0;
        while (!done) begin
            if (cyc > 1000) begin
                failures++;
                $display("FAIL %s timeout after %0d beats want %0d", name, idx, exp_q.size());
                break;
            end
            e = exp_q[idx];
            checks++;
            if (vv[sel] !== 1'b1) begin
                failures++;
                $display("FAIL %s valid beat%0d got %b want 1", name, idx, vv[sel]);
                break;
            end
            if (o_ix[sel] !== CW'(e.x) || o_iy[sel] !== CW'(e.y) || o_iz[sel] !== CW'(e.z) ||
                vl[sel] !== 1'(e.last) || o_reason[sel] !== 2'(e.reason)) begin
                failures++;
                $display("FAIL %s beat%0d got (%0d,%0d,%0d) last=%b reason=%0d want (%0d,%0d,%0d) last=%0d reason=%0d",
                         name, idx, o_ix[sel], o_iy[sel], o_iz[sel], vl[sel], o_reason[sel],
                         e.x, e.y, e.z, e.last, e.reason);
            end
            if (idx == rst_at) begin
                rst = 1'b1;
                #1;
                checks++;
                if ({vv[sel], vl[sel], o_reason[sel], o_ix[sel], o_iy[sel], o_iz[sel]} !== '0) begin
                    failures++;
                    $display("FAIL %s in-reset outputs got v=%b l=%b r=%0d (%0d,%0d,%0d) want all 0",
                             name, vv[sel], vl[sel], o_reason[sel], o_ix[sel], o_iy[sel], o_iz[sel]);
                end
                @(negedge clk);
                rst = 1'b0;
                @(negedge clk);
                done = 1'b1;
            end else begin
                hs = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (idx == abort_at) begin
                    abort = 1'b1;
                    hs    = 1'b1;
                end
                vox_ready[sel] = hs;
                @(negedge clk);
                abort = 1'b0;
                if (rnd) scramble_inputs();
                if (hs) begin
                    if (e.last != 0 || idx == abort_at) done = 1'b1;
                    idx++;
                end
                cyc++;
            end
        end
        start_valid[sel] = 1'b0;
        want_cnt = (abort_at >= 0) ? abort_at + 1 : (rst_at >= 0) ? rst_at : exp_q.size();
        checks++;
        if (idx != want_cnt) begin
            failures++;
            $display("FAIL %s beats delivered got %0d want %0d", name, idx, want_cnt);
        end
        checks++;
        if (vv[sel] !== 1'b0 || sr[sel] !== 1'b1) begin
            failures++;
            $display("FAIL %s end-of-ray got valid=%b ready=%b want valid=0 ready=1", name, vv[sel], sr[sel]);
        end
        vox_ready[sel] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (vv[sel] !== 1'b0) stray = 1'b1;
        end
        vox_ready[sel] = 1'b0;
        checks++;
        if (stray) begin
            failures++;
            $display("FAIL %s extra beat after ray end got valid=1 want 0", name);
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (sr[k] !== 1'b1 || vv[k] !== 1'b0 || vl[k] !== 1'b0 || o_reason[k] !== 2'b00 ||
                o_ix[k] !== '0 || o_iy[k] !== '0 || o_iz[k] !== '0) begin
                failures++;
                $display("FAIL reset dut%0d got ready=%b valid=%b last=%b reason=%0d (%0d,%0d,%0d) want 1,0,0,0,(0,0,0)",
                         k, sr[k], vv[k], vl[k], o_reason[k], o_ix[k], o_iy[k], o_iz[k]);
            end
        end
    endtask

    task automatic test_idle_abort();
        abort = 1'b1;
        repeat (2) @(negedge clk);
        abort = 1'b0;
        checks++;
        if (sr[0] !== 1'b1 || vv[0] !== 1'b0) begin
            failures++;
            $display("FAIL idle_abort got ready=%b valid=%b want 1,0", sr[0], vv[0]);
        end
    endtask

    task automatic test_diagonal();
        set_ray(0, 0, 0, 1, 1, 1, 1, 2, 3, 3, 3, 3);
        run_ray(0, 1'b0, -1, -1, "diagonal");
    endtask

    task automatic test_x_edge();
        set_ray(30, 5, 5, 1, 1, 1, 0, TSAT, TSAT, 1, 0, 0);
        run_ray(0, 1'b0, -1, -1, "x_edge");
    endtask

    task automatic test_wrap();
        set_ray(0, 3, 3, 0, 1, 1, 0, TSAT, TSAT, 1, 1, 1);
        run_ray(0, 1'b0, -1, -1, "wrap");
    endtask

    task automatic test_oob_start();
        set_ray(40, 0, 0, 1, 1, 1, 5, 6, 7, 1, 1, 1);
        run_ray(0, 1'b0, -1, -1, "oob_start");
    endtask

    task automatic test_step_limit();
        set_ray(5, 5, 5, 1, 1, 1, 1, 2, 3, 3, 3, 3);
        run_ray(1, 1'b1, -1, -1, "step_limit");
    endtask

    task automatic test_abort();
        set_ray(2, 2, 2, 1, 1, 1, 1, 2, 3, 3, 3, 3);
        run_ray(0, 1'b0, 2, -1, "abort");
    endtask

    task automatic test_reset_mid_ray();
        set_ray(2, 2, 2, 1, 1, 1, 1, 2, 3, 3, 3, 3);
        run_ray(0, 1'b0, -1, 2, "rst_mid_ray");
    endtask

    task automatic test_random();
        for (int r = 0; r < 12; r++) begin
            set_ray($urandom_range(0, 35), $urandom_range(0, 33), $urandom_range(0, 32),
                    1'($urandom), 1'($urandom), 1'($urandom),
                    (r % 3 == 0) ? $urandom_range(65000, TSAT) : $urandom_range(0, 200),
                    $urandom_range(0, 300), $urandom_range(0, TSAT),
                    $urandom_range(0, 40), $urandom_range(1, 40),
                    (r % 4 == 0) ? $urandom_range(30000, TSAT) : $urandom_range(0, 60));
            run_ray(r % 2, 1'b1, -1, -1, $sformatf("random%0d", r));
        end
    endtask

    initial begin
        rst = 1'b1;
        abort = 1'b0;
        for (int k = 0; k < 2; k++) begin
            start_valid[k] = 1'b0;
            vox_ready[k]   = 1'b0;
        end
        set_ray(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_idle_abort();
        test_diagonal();
        test_x_edge();
        test_wrap();
        test_oob_start();
        test_step_limit();
        test_abort();
        test_reset_mid_ray();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
